i2c_master_tx: RTL and testbench

I2C_MASTER_TX -- requirements
Module: i2c_master_tx

---
 rtl/i2c_pkg.sv | 33 +++
 rtl/i2c_tick_gen.sv | 32 +++
 rtl/i2c_master_tx.sv | 165 ++++++++++++++++
 tb/tb_i2c_master_tx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM encodings, default target address and divider,
// line-drive record and packet byte selection.
package i2c_pkg;

  localparam logic [6:0] I2C_SLAVE_ADDR = 7'h42;
  localparam int         I2C_CLK_DIV    = 250;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ADDR  = 3'd2,
    ST_ACK_A = 3'd3,
    ST_DATA  = 3'd4,
    ST_ACK_D = 3'd5,
    ST_STOP  = 3'd6
  } i2c_state_e;

  // Open-drain intent: a set bit pulls the line low, clear leaves it released.
  typedef struct packed {
    logic scl_low;
    logic sda_low;
  } i2c_drive_t;

  function automatic logic [7:0] pkt_byte(input logic [31:0] pkt, input logic [1:0] idx);
    case (idx)
      2'd0:    return pkt[31:24];
      2'd1:    return pkt[23:16];
      2'd2:    return pkt[15:8];
      default: return pkt[7:0];
    endcase
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: one-cycle tick every CLK_DIV cycles while enabled,
// restarting from zero whenever the enable drops.
module i2c_tick_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = I2C_CLK_DIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == LAST) cnt_d = '0;
    else                        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/i2c_master_tx.sv
// Write-only I2C master: sends {SLAVE_ADDR,W} then the four packet bytes MSB first,
// checking each ACK slot and ending with STOP; lines are only ever pulled low.
module i2c_master_tx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_SLAVE_ADDR,
  parameter int         CLK_DIV    = I2C_CLK_DIV
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        nack,
  inout  wire         i2c_sda,
  inout  wire         i2c_scl,
  output logic [2:0]  state_out
);

  i2c_state_e  state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  sr_q, sr_d;
  logic [31:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        nack_q, nack_d;
  logic        nflag_q, nflag_d;

  logic        tick, end_of_bit, sda_in;
  i2c_drive_t  drv;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK   (CLK),
    .RST   (RST),
    .en_i  (busy_q),
    .tick_o(tick)
  );

  assign sda_in     = i2c_sda;
  assign end_of_bit = tick && (phase_q == 2'd3);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sr_d    = sr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    nack_d  = 1'b0;
    nflag_d = nflag_q;
    drv     = '0;

    if (tick) phase_d = phase_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        // done_q blocks a start arriving in the same cycle as the done pulse.
        if (start && !busy_q && !done_q) begin
          busy_d  = 1'b1;
          data_d  = tx_data;
          state_d = ST_START;
          phase_d = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          nflag_d = 1'b0;
        end
      end
      // Two bit periods: bus-free with both lines released, then SDA low under
      // a high SCL for two ticks and SCL low for two; the packet totals 48 periods.
      ST_START: begin
        drv.sda_low = bit_q[0];
        drv.scl_low = bit_q[0] && phase_q[1];
        if (end_of_bit) begin
          if (bit_q[0]) begin
            state_d = ST_ADDR;
            bit_d   = 3'd0;
            sr_d    = {SLAVE_ADDR, 1'b0};
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_ADDR, ST_DATA: begin
        drv.sda_low = !sr_q[7];
        drv.scl_low = !phase_q[1];
        if (end_of_bit) begin
          sr_d  = {sr_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == ST_ADDR) ? ST_ACK_A : ST_ACK_D;
        end
      end
      ST_ACK_A, ST_ACK_D: begin
        drv.scl_low = !phase_q[1];
        if (tick && phase_q == 2'd2) nflag_d = nflag_q | sda_in;
        if (end_of_bit) begin
          if (nflag_q) begin
            state_d = ST_STOP;
          end else if (state_q == ST_ACK_A) begin
            state_d = ST_DATA;
            byte_d  = 2'd0;
            sr_d    = pkt_byte(data_q, 2'd0);
          end else if (byte_q == 2'd3) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
            byte_d  = byte_q + 2'd1;
            sr_d    = pkt_byte(data_q, byte_q + 2'd1);
          end
        end
      end
      ST_STOP: begin
        drv.scl_low = (phase_q == 2'd0);
        drv.sda_low = !phase_q[1];
        if (end_of_bit) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          nack_d  = nflag_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      nflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      nflag_q <= nflag_d;
    end
  end

  // Reset releases the bus in the same cycle it is asserted.
  assign i2c_sda = (drv.sda_low && !RST) ? 1'b0 : 1'bz;
  assign i2c_scl = (drv.scl_low && !RST) ? 1'b0 : 1'bz;

  assign busy      = busy_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: pull-ups, a clocked slave model at 7'h42 that can NACK a
// chosen byte, a vector table of packets and hand sequences for start/reset corners.
module tb_i2c_master_tx;

  localparam int CLK_DIV  = 4;
  localparam int FULL_LEN = 48 * 4 * CLK_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] tx_data = '0;
  logic        busy, done, nack;
  logic [2:0]  state_out;
  wire         sda, scl;

  pullup (sda);
  pullup (scl);

  logic slave_low = 1'b0;
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_tx #(.SLAVE_ADDR(7'h42), .CLK_DIV(CLK_DIV)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .start    (start),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .nack     (nack),
    .i2c_sda  (sda),
    .i2c_scl  (scl),
    .state_out(state_out)
  );

  always #5 CLK = ~CLK;

  // Slave model, sampled once per CLK so simultaneous SCL/SDA moves are not
  // mistaken for START/STOP conditions.
  int         nack_idx  = -1;
  int         start_cnt = 0;
  int         stop_cnt  = 0;
  int         nbytes    = 0;
  int         sbit      = 0;
  logic       active    = 1'b0;
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  logic [7:0] shreg     = '0;
  logic [7:0] rx [8];

  always @(negedge CLK) begin
    if (prev_scl && scl && prev_sda && !sda) begin
      start_cnt++; active = 1'b1; sbit = 0; nbytes = 0; slave_low = 1'b0;
    end else if (prev_scl && scl && !prev_sda && sda) begin
      stop_cnt++; active = 1'b0; slave_low = 1'b0;
    end else if (active && !prev_scl && scl) begin
      if (sbit < 8) shreg = {shreg[6:0], sda};
      sbit++;
      if (sbit == 8 && nbytes < 8) begin rx[nbytes] = shreg; nbytes++; end
    end else if (active && prev_scl && !scl) begin
      if (sbit == 8)      slave_low = (nbytes - 1 != nack_idx) && (rx[0][7:1] == 7'h42);
      else if (sbit == 9) begin slave_low = 1'b0; sbit = 0; end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One-cycle start pulse; returns at the first negedge after the accepting edge.
  task automatic accept_pulse(input string tag, input logic [31:0] d);
    @(negedge CLK); start = 1'b1; tx_data = d;
    @(negedge CLK); start = 1'b0; tx_data = '0;
    chk({tag, "/busy_after_accept"}, int'(busy), 1);
    chk({tag, "/state_after_accept"}, int'(state_out), 1);
  endtask

  task automatic finish_txn(input string tag, input int cyc0, input logic exp_nack,
                            input int exp_nb, input logic [39:0] exp_bytes, input int exp_len,
                            input int st0, input int sp0, input bit poke);
    int cyc = cyc0;
    while (done !== 1'b1 && cyc < exp_len + 64) begin @(negedge CLK); cyc++; end
    checks++;
    if (done !== 1'b1 || cyc < exp_len - CLK_DIV || cyc > exp_len + CLK_DIV) begin
      errors++;
      $display("FAIL %s/len: done=%0b after %0d cycles, expected done after %0d +/- %0d",
               tag, done, cyc, exp_len, CLK_DIV);
    end
    chk({tag, "/nack"}, int'(nack), int'(exp_nack));
    chk({tag, "/busy_at_done"}, int'(busy), 0);
    chk({tag, "/state_at_done"}, int'(state_out), 0);
    if (poke) begin start = 1'b1; tx_data = 32'hBAD0_BAD0; end
    @(negedge CLK);
    start = 1'b0;
    chk({tag, "/done_one_cycle"}, int'(done), 0);
    chk({tag, "/nack_one_cycle"}, int'(nack), 0);
    chk({tag, "/busy_after_done"}, int'(busy), 0);
    chk({tag, "/byte_count"}, nbytes, exp_nb);
    chk({tag, "/start_conditions"}, start_cnt - st0, 1);
    chk({tag, "/stop_conditions"}, stop_cnt - sp0, 1);
    for (int k = 0; k < exp_nb && k < 5; k++)
      chk($sformatf("%s/rx%0d", tag, k), int'(rx[k]), int'(exp_bytes[39-8*k -: 8]));
  endtask

  typedef struct {
    logic [31:0] data;
    int          nack_at;
    logic        exp_nack;
    int          exp_nb;
    logic [39:0] exp_bytes;
    int          exp_len;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int st0, sp0, cyc, done_seen;

    vecs[0] = '{32'h0105_0300, -1, 1'b0, 5, 40'h84_01_05_03_00, FULL_LEN};
    vecs[1] = '{32'hA53C_FF81, -1, 1'b0, 5, 40'h84_A5_3C_FF_81, FULL_LEN};
    vecs[2] = '{32'h1234_5678,  0, 1'b1, 1, 40'h84_00_00_00_00, 48 * CLK_DIV};
    vecs[3] = '{32'hDEAD_BEEF,  2, 1'b1, 3, 40'h84_DE_AD_00_00, 120 * CLK_DIV};

    repeat (3) @(negedge CLK);
    chk("reset/busy", int'(busy), 0);
    chk("reset/done", int'(done), 0);
    chk("reset/nack", int'(nack), 0);
    chk("reset/state", int'(state_out), 0);
    chk("reset/sda", int'(sda), 1);
    chk("reset/scl", int'(scl), 1);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 4; i++) begin
      nack_idx = vecs[i].nack_at;
      st0 = start_cnt; sp0 = stop_cnt;
      accept_pulse($sformatf("vec%0d", i), vecs[i].data);
      finish_txn($sformatf("vec%0d", i), 0, vecs[i].exp_nack, vecs[i].exp_nb,
                 vecs[i].exp_bytes, vecs[i].exp_len, st0, sp0, 1'b0);
      repeat (5) @(negedge CLK);
    end

    // start held for three cycles with changing data, a second start mid-transfer,
    // and a start coinciding with done: only the first-cycle packet goes out.
    nack_idx = -1;
    st0 = start_cnt; sp0 = stop_cnt;
    @(negedge CLK); start = 1'b1; tx_data = 32'h1122_3344;
    @(negedge CLK); tx_data = 32'h5566_7788;
    chk("hold/busy_after_accept", int'(busy), 1);
    @(negedge CLK); tx_data = 32'h99AA_BBCC;
    @(negedge CLK); start = 1'b0; tx_data = '0;
    repeat (297) @(negedge CLK);
    start = 1'b1; tx_data = 32'hCAFE_F00D;
    @(negedge CLK); start = 1'b0; tx_data = '0;
    finish_txn("hold", 301, 1'b0, 5, 40'h84_11_22_33_44, FULL_LEN, st0, sp0, 1'b1);
    repeat (40) @(negedge CLK);
    chk("hold/no_second_txn", start_cnt - st0, 1);
    chk("hold/idle_after", int'(busy), 0);

    // Reset pulse while sending data aborts without STOP or done.
    accept_pulse("abort", 32'hF0E1_D2C3);
    cyc = 0;
    while (state_out !== 3'd4 && cyc < 1000) begin @(negedge CLK); cyc++; end
    repeat (20) @(negedge CLK);
    chk("abort/in_data", int'(state_out), 4);
    RST = 1'b1;
    @(negedge CLK);
    chk("abort/busy", int'(busy), 0);
    chk("abort/sda", int'(sda), 1);
    chk("abort/scl", int'(scl), 1);
    chk("abort/state", int'(state_out), 0);
    RST = 1'b0;
    done_seen = 0;
    repeat (100) begin @(negedge CLK); if (done === 1'b1) done_seen++; end
    chk("abort/no_done", done_seen, 0);
    st0 = start_cnt; sp0 = stop_cnt;
    accept_pulse("after_abort", 32'hC0FF_EE00);
    finish_txn("after_abort", 0, 1'b0, 5, 40'h84_C0_FF_EE_00, FULL_LEN, st0, sp0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
